raytracing_scheduler: RTL and testbench

RAYTRACING_SCHEDULER -- requirements
Module: raytracing_scheduler

---
 rtl/raytracing_scheduler_pkg.sv | 41 ++++
 rtl/raytracing_scheduler_if.sv | 12 +
 rtl/raytracing_drain_counter.sv | 51 +++++
 rtl/raytracing_scheduler.sv | 163 ++++++++++++++++
 tb/tb_raytracing_scheduler.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/raytracing_scheduler_pkg.sv
// Shared types and constants for the ray-tracing row scheduler, its drain counter and the framebuffer port.
package raytracing_scheduler_pkg;

  localparam int unsigned N_WORKERS        = 10;
  localparam int unsigned JOBS_SUBDIVISION = 64;
  localparam int unsigned WIDTH            = N_WORKERS * JOBS_SUBDIVISION;
  localparam int unsigned HEIGHT           = 480;

  localparam int unsigned PX_X_B      = 12;
  localparam int unsigned PX_Y_B      = 10;
  localparam int unsigned PX_Y_PROD_B = 2 * PX_Y_B;
  localparam int unsigned PX_Y_SQRD_B = 16;
  localparam int unsigned FB_ADDR_B   = 19;
  localparam int unsigned COLOR_B     = 12;

  typedef logic [COLOR_B-1:0] Color;

  localparam Color BACKGROUND_COLOR = 12'h248;

  typedef struct packed {
    logic signed [PX_X_B-1:0] cx;
    logic signed [PX_X_B-1:0] cy;
    logic signed [PX_X_B-1:0] cz;
    logic [PX_X_B-1:0]        radius;
    Color                     color;
  } sphere_t;

  typedef struct packed {
    sphere_t s2;
    sphere_t s1;
    sphere_t s0;
  } World;

  // |y| never exceeds HEIGHT/2, so the square fits the narrower result.
  function automatic logic [PX_Y_SQRD_B-1:0] y_sqrd(input logic signed [PX_Y_B-1:0] y);
    logic signed [PX_Y_PROD_B-1:0] p;
    p = PX_Y_PROD_B'(y) * PX_Y_PROD_B'(y);
    return PX_Y_SQRD_B'(p);
  endfunction

endpackage

// File: rtl/raytracing_scheduler_if.sv
// Framebuffer write channel: address/data held under valid until the framebuffer accepts.
interface raytracing_scheduler_if;
  import raytracing_scheduler_pkg::*;

  logic [FB_ADDR_B-1:0] fb_addr;
  Color                 fb_data;
  logic                 fb_valid;
  logic                 fb_ready;

  modport master (output fb_addr, output fb_data, output fb_valid, input fb_ready);
  modport slave  (input fb_addr, input fb_data, input fb_valid, output fb_ready);
endinterface

// File: rtl/raytracing_drain_counter.sv
// Walks (k outer, w inner) over one row's worker buffers and tracks the matching framebuffer address.
module raytracing_drain_counter
  import raytracing_scheduler_pkg::FB_ADDR_B;
#(
  parameter int unsigned N_WORKERS        = 10,
  parameter int unsigned JOBS_SUBDIVISION = 64,
  parameter int unsigned WIDTH            = 640,
  parameter int unsigned ROW_B            = 9,
  parameter int unsigned W_B              = 4,
  parameter int unsigned K_B              = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 advance,
  input  logic [ROW_B-1:0]     load_row,
  output logic [FB_ADDR_B-1:0] fb_addr,
  output logic [W_B-1:0]       nxt_w_c,
  output logic [K_B-1:0]       nxt_k_c,
  output logic                 last_c
);

  logic [W_B-1:0] w;
  logic [K_B-1:0] k;
  logic           w_wrap_c;

  // k*N_WORKERS + w is linear in drain order, so the address simply increments.
  always_comb begin
    w_wrap_c = (w == W_B'(N_WORKERS - 1));
    nxt_w_c  = w_wrap_c ? '0 : w + W_B'(1);
    nxt_k_c  = w_wrap_c ? k + K_B'(1) : k;
    last_c   = w_wrap_c && (k == K_B'(JOBS_SUBDIVISION - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w       <= '0;
      k       <= '0;
      fb_addr <= '0;
    end else if (load) begin
      w       <= '0;
      k       <= '0;
      fb_addr <= FB_ADDR_B'(load_row) * FB_ADDR_B'(WIDTH);
    end else if (advance) begin
      w       <= nxt_w_c;
      k       <= nxt_k_c;
      fb_addr <= fb_addr + FB_ADDR_B'(1);
    end
  end

endmodule

// File: rtl/raytracing_scheduler.sv
// Frame scheduler: launches all workers on one row, then drains their buffers to the framebuffer row by row.
module raytracing_scheduler
  import raytracing_scheduler_pkg::Color, raytracing_scheduler_pkg::World,
         raytracing_scheduler_pkg::PX_X_B, raytracing_scheduler_pkg::PX_Y_B,
         raytracing_scheduler_pkg::PX_Y_SQRD_B, raytracing_scheduler_pkg::BACKGROUND_COLOR,
         raytracing_scheduler_pkg::y_sqrd;
#(
  parameter int unsigned N_WORKERS        = raytracing_scheduler_pkg::N_WORKERS,
  parameter int unsigned JOBS_SUBDIVISION = raytracing_scheduler_pkg::JOBS_SUBDIVISION,
  parameter int unsigned WIDTH            = raytracing_scheduler_pkg::WIDTH,
  parameter int unsigned HEIGHT           = raytracing_scheduler_pkg::HEIGHT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  World                          world_in,
  input  logic [1:0]                    num_spheres_in,
  output World                          world,
  output logic [1:0]                    num_spheres,
  output logic                          activate,
  output logic signed [PX_X_B-1:0]      pixel_start_x [N_WORKERS],
  output logic signed [PX_Y_B-1:0]      pixel_y,
  output logic [PX_Y_SQRD_B-1:0]        pixel_y_sqrd,
  input  logic [N_WORKERS-1:0]          worker_busy,
  input  Color                          worker_buffer [N_WORKERS][JOBS_SUBDIVISION],
  raytracing_scheduler_if.master        fb,
  output logic                          frame_busy,
  output logic                          frame_done
);

  localparam int unsigned ROW_B = $clog2(HEIGHT);
  localparam int unsigned W_B   = (N_WORKERS > 1) ? $clog2(N_WORKERS) : 1;
  localparam int unsigned K_B   = (JOBS_SUBDIVISION > 1) ? $clog2(JOBS_SUBDIVISION) : 1;

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_START, WAIT_DONE, DRAIN, NEXT_ROW, DONE} state_t;

  state_t                    state, state_d;
  logic [ROW_B-1:0]          row, row_d;
  World                      world_d;
  logic [1:0]                num_spheres_d;
  logic                      activate_d, frame_busy_d, frame_done_d, fb_valid_d;
  Color                      fb_data_d;
  logic signed [PX_Y_B-1:0]  pixel_y_d;
  logic                      cnt_load, cnt_advance, cnt_last_c, handshake_c;
  logic [W_B-1:0]            nxt_w_c;
  logic [K_B-1:0]            nxt_k_c;

  for (genvar g = 0; g < N_WORKERS; g++) begin : g_start_x
    assign pixel_start_x[g] = PX_X_B'(g) - PX_X_B'(WIDTH / 2);
  end

  assign handshake_c = fb.fb_valid && fb.fb_ready;
  assign pixel_y_d   = PX_Y_B'(HEIGHT / 2) - PX_Y_B'(row_d);

  raytracing_drain_counter #(
    .N_WORKERS(N_WORKERS), .JOBS_SUBDIVISION(JOBS_SUBDIVISION), .WIDTH(WIDTH),
    .ROW_B(ROW_B), .W_B(W_B), .K_B(K_B)
  ) u_drain_counter (
    .clk(clk), .rst(rst), .load(cnt_load), .advance(cnt_advance), .load_row(row_d),
    .fb_addr(fb.fb_addr), .nxt_w_c(nxt_w_c), .nxt_k_c(nxt_k_c), .last_c(cnt_last_c)
  );

  // Next-state and next-output logic; an empty scene bypasses the workers entirely.
  always_comb begin
    state_d       = state;
    row_d         = row;
    world_d       = world;
    num_spheres_d = num_spheres;
    activate_d    = activate;
    frame_busy_d  = frame_busy;
    frame_done_d  = 1'b0;
    fb_valid_d    = fb.fb_valid;
    fb_data_d     = fb.fb_data;
    cnt_load      = 1'b0;
    cnt_advance   = 1'b0;
    case (state)
      IDLE: if (start) begin
        world_d       = world_in;
        num_spheres_d = num_spheres_in;
        row_d         = '0;
        frame_busy_d  = 1'b1;
        if (num_spheres_in == 2'd0) begin
          state_d    = DRAIN;
          cnt_load   = 1'b1;
          fb_valid_d = 1'b1;
          fb_data_d  = BACKGROUND_COLOR;
        end else begin
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        activate_d = 1'b1;
        state_d    = WAIT_START;
      end
      WAIT_START: if (&worker_busy) state_d = WAIT_DONE;
      WAIT_DONE: if (worker_busy == '0) begin
        activate_d = 1'b0;
        state_d    = DRAIN;
        cnt_load   = 1'b1;
        fb_valid_d = 1'b1;
        fb_data_d  = worker_buffer[0][0];
      end
      DRAIN: if (handshake_c) begin
        if (cnt_last_c) begin
          fb_valid_d = 1'b0;
          if (row == ROW_B'(HEIGHT - 1)) begin
            state_d      = DONE;
            frame_done_d = 1'b1;
            frame_busy_d = 1'b0;
          end else begin
            state_d = NEXT_ROW;
          end
        end else begin
          cnt_advance = 1'b1;
          fb_data_d   = (num_spheres == 2'd0) ? BACKGROUND_COLOR : worker_buffer[nxt_w_c][nxt_k_c];
        end
      end
      NEXT_ROW: begin
        row_d = row + ROW_B'(1);
        if (num_spheres == 2'd0) begin
          state_d    = DRAIN;
          cnt_load   = 1'b1;
          fb_valid_d = 1'b1;
          fb_data_d  = BACKGROUND_COLOR;
        end else begin
          state_d = LAUNCH;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // pixel_y terms follow row_d, so they settle one cycle before activate rises.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      row          <= '0;
      world        <= '0;
      num_spheres  <= '0;
      activate     <= 1'b0;
      frame_busy   <= 1'b0;
      frame_done   <= 1'b0;
      fb.fb_valid  <= 1'b0;
      fb.fb_data   <= '0;
      pixel_y      <= PX_Y_B'(HEIGHT / 2);
      pixel_y_sqrd <= y_sqrd(PX_Y_B'(HEIGHT / 2));
    end else begin
      state        <= state_d;
      row          <= row_d;
      world        <= world_d;
      num_spheres  <= num_spheres_d;
      activate     <= activate_d;
      frame_busy   <= frame_busy_d;
      frame_done   <= frame_done_d;
      fb.fb_valid  <= fb_valid_d;
      fb.fb_data   <= fb_data_d;
      pixel_y      <= pixel_y_d;
      pixel_y_sqrd <= y_sqrd(pixel_y_d);
    end
  end

endmodule

// File: tb/tb_raytracing_scheduler.sv
// Scoreboard bench: stimulus queues expected framebuffer writes, a negedge monitor pops and compares them.
module tb_raytracing_scheduler;
  import raytracing_scheduler_pkg::*;

  localparam int unsigned TB_N = 10;
  localparam int unsigned TB_J = 8;
  localparam int unsigned TB_W = 80;
  localparam int unsigned TB_H = 480;

  logic clk = 1'b0;
  logic rst, start;
  World world_in, world, world_a, world_b;
  logic [1:0] num_spheres_in, num_spheres;
  logic activate, frame_busy, frame_done;
  logic signed [11:0] pixel_start_x [TB_N];
  logic signed [PX_Y_B-1:0] pixel_y;
  logic [PX_Y_SQRD_B-1:0] pixel_y_sqrd;
  logic [TB_N-1:0] worker_busy;
  Color worker_buffer [TB_N][TB_J];

  raytracing_scheduler_if fb_if();

  raytracing_scheduler #(
    .N_WORKERS(TB_N), .JOBS_SUBDIVISION(TB_J), .WIDTH(TB_W), .HEIGHT(TB_H)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .world_in(world_in), .num_spheres_in(num_spheres_in),
    .world(world), .num_spheres(num_spheres), .activate(activate), .pixel_start_x(pixel_start_x),
    .pixel_y(pixel_y), .pixel_y_sqrd(pixel_y_sqrd), .worker_busy(worker_busy),
    .worker_buffer(worker_buffer), .fb(fb_if), .frame_busy(frame_busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [30:0] exp_q[$];
  int writes = 0, act_pulses = 0, act_base = 0, done_pulses = 0;
  logic act_prev = 1'b0, stall_prev = 1'b0;
  logic [30:0] stall_word;
  Color data53 = '0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: inputs change just after posedge, so negedge sees the values the next edge will use.
  always @(negedge clk) begin : mon
    int yv;
    if (rst) begin
      stall_prev = 1'b0;
      act_prev   = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid_held", fb_if.fb_valid, 1);
        check("stall_word_held", {fb_if.fb_addr, fb_if.fb_data}, stall_word);
      end
      if (fb_if.fb_valid && fb_if.fb_ready) begin
        writes++;
        if (num_spheres != 2'd0 && fb_if.fb_addr == 19'd53) data53 = fb_if.fb_data;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got addr %0d data %0h expected none", fb_if.fb_addr, fb_if.fb_data);
        end else begin
          check("fb_write", {fb_if.fb_addr, fb_if.fb_data}, exp_q.pop_front());
        end
      end
      stall_prev = fb_if.fb_valid && !fb_if.fb_ready;
      stall_word = {fb_if.fb_addr, fb_if.fb_data};
      if (activate && !act_prev) begin
        act_pulses++;
        yv = 240 - (act_pulses - 1 - act_base);
        check("pixel_y", pixel_y, yv);
        check("pixel_y_sqrd", pixel_y_sqrd, yv * yv);
      end
      act_prev = activate;
      if (frame_done) done_pulses++;
    end
  end

  // Worker model: all busy one cycle after activate rises, idle again 100 cycles later.
  initial begin : workers
    logic launched;
    launched = 1'b0;
    worker_busy = '0;
    forever begin
      tick();
      if (activate && !launched) begin
        launched = 1'b1;
        tick();
        worker_busy = '1;
        repeat (100) tick();
        worker_busy = '0;
      end else if (!activate) begin
        launched = 1'b0;
      end
    end
  end

  initial begin : main
    int guard, acts0, done0, w0;
    rst = 1'b1;
    start = 1'b0;
    world_in = '0;
    num_spheres_in = 2'd0;
    fb_if.fb_ready = 1'b1;
    world_a = World'({6{32'h1357_9BDF}});
    world_b = World'({6{32'h2468_ACE0}});
    for (int w = 0; w < TB_N; w++)
      for (int k = 0; k < TB_J; k++)
        worker_buffer[w][k] = Color'(w * 16 + k);
    worker_buffer[3][5] = 12'hABC;

    repeat (3) tick();
    check("rst_activate", activate, 0);
    check("rst_fb_valid", fb_if.fb_valid, 0);
    check("rst_frame_busy", frame_busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_fb_addr", fb_if.fb_addr, 0);
    check("rst_world", world, 0);
    check("rst_num_spheres", num_spheres, 0);
    check("start_x_w0", pixel_start_x[0], -40);
    check("start_x_w9", pixel_start_x[9], -31);
    rst = 1'b0;
    tick();

    // Frame 1: rows 0..6 drain completely, then reset lands in WAIT_DONE of row 7.
    act_base = act_pulses;
    for (int r = 0; r < 7; r++)
      for (int k = 0; k < TB_J; k++)
        for (int w = 0; w < TB_N; w++)
          exp_q.push_back({19'(r * 80 + k * 10 + w), worker_buffer[w][k]});
    world_in = world_a;
    num_spheres_in = 2'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (!((act_pulses - act_base) == 8 && worker_busy == '1) && guard < 5000) begin tick(); guard++; end
    check("reach_row7_wait_done", (act_pulses - act_base) == 8 && worker_busy == '1, 1);
    repeat (5) tick();
    check("row7_activate_high", activate, 1);
    check("row7_world_held", world, world_a);
    rst = 1'b1;
    tick();
    check("abort_activate", activate, 0);
    check("abort_frame_busy", frame_busy, 0);
    check("abort_fb_valid", fb_if.fb_valid, 0);
    check("abort_fb_addr", fb_if.fb_addr, 0);
    check("abort_world_clear", world, 0);
    rst = 1'b0;
    tick();
    check("abort_no_frame_done", done_pulses, 0);
    check("rows0_6_all_written", exp_q.size(), 0);
    check("addr53_data", data53, 12'hABC);
    check("one_activate_per_row", act_pulses - act_base, 8);
    guard = 0;
    while (worker_busy != '0 && guard < 200) begin tick(); guard++; end

    // Frame 2: restart renders from row 0; abort once row 1 launches.
    act_base = act_pulses;
    for (int k = 0; k < TB_J; k++)
      for (int w = 0; w < TB_N; w++)
        exp_q.push_back({19'(k * 10 + w), worker_buffer[w][k]});
    world_in = world_b;
    num_spheres_in = 2'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while ((act_pulses - act_base) < 2 && guard < 1000) begin tick(); guard++; end
    check("restart_row1_launch", act_pulses - act_base, 2);
    check("restart_row0_written", exp_q.size(), 0);
    check("restart_world", world, world_b);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    guard = 0;
    while (worker_busy != '0 && guard < 200) begin tick(); guard++; end

    // Frame 3: empty scene, a 5-cycle fb_ready stall, and a start/world change ignored mid-frame.
    acts0 = act_pulses;
    done0 = done_pulses;
    w0 = writes;
    for (int i = 0; i < TB_W * TB_H; i++) exp_q.push_back({19'(i), BACKGROUND_COLOR});
    world_in = world_a;
    num_spheres_in = 2'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while ((writes - w0) < 500 && guard < 2000) begin tick(); guard++; end
    fb_if.fb_ready = 1'b0;
    repeat (5) begin
      tick();
      check("stall_valid_main", fb_if.fb_valid, 1);
    end
    fb_if.fb_ready = 1'b1;
    guard = 0;
    while ((writes - w0) < 20000 && guard < 30000) begin tick(); guard++; end
    world_in = world_b;
    num_spheres_in = 2'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("midframe_world", world, world_a);
    check("midframe_num_spheres", num_spheres, 0);
    check("midframe_busy", frame_busy, 1);
    guard = 0;
    while (!frame_done && guard < 40000) begin tick(); guard++; end
    check("frame_done_seen", frame_done, 1);
    check("world_at_done", world, world_a);
    tick();
    check("frame_done_one_cycle", frame_done, 0);
    check("frame_busy_after_done", frame_busy, 0);
    check("bg_done_count", done_pulses - done0, 1);
    check("bg_no_activate", act_pulses - acts0, 0);
    check("bg_write_count", writes - w0, TB_W * TB_H);
    check("bg_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
